slc3_stim_sequencer: RTL and testbench

- Synthesizable, script-driven stimulus and check engine for the SLC-3 top level.
- Replays a stored script of switch settings, Run/Continue/DUT-reset pulses and timed waits, then compares an observed DUT value against expected values.
- Lets directed lab tests (I/O, XOR, multiply, sort) run on the board or in simulation without hand-timed delays.
- Sits beside the SLC-3 top level; drives its Run, Continue, Reset and switch inputs.

---
 rtl/slc3_stim_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_slc3_stim_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slc3_stim_sequencer.sv
// rtl/slc3_stim_sequencer.sv - script-driven stimulus and check engine for the SLC-3 top level
//
// Replays a stored script of switch settings, active-low Run/Continue/DUT-reset
// pulses and timed waits against the SLC-3, and counts CHECK results against an
// observed DUT word.
//
// Script entry: {op[2:0], value[DATA_W-1:0], delay[DELAY_W-1:0]}
//   op 0 WAIT, 1 SET_S, 2 PULSE_CONT, 3 PULSE_RUN, 4 CHECK, 5 DUT_RESET,
//   6 reserved (acts as WAIT), 7 END
//
// Ports:
//   Clk, Reset                   clock, asynchronous active-high reset
//   script_we/addr/wdata         script RAM write port (dropped while busy)
//   start, abort                 begin at step 0 / stop immediately (abort wins)
//   observe                      DUT value compared by CHECK
//   S                            switch value to the DUT
//   Run_n, Continue_n,
//   dut_reset_n                  active-low DUT controls, pulsed PULSE_W cycles
//   busy, done, overrun          status; done held until next start
//   pass_cnt, fail_cnt           saturating CHECK counters
//   fail_step, fail_obs          first failing CHECK (only with SEQ_FAIL_CAPTURE_EN)
//
// Optional feature macro: SEQ_FAIL_CAPTURE_EN

module slc3_stim_sequencer #(
    parameter int DATA_W  = 16,
    parameter int STEPS   = 32,
    parameter int DELAY_W = 16,
    parameter int PULSE_W = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          script_we,
    input  logic [$clog2(STEPS)-1:0]      script_addr,
    input  logic [3+DATA_W+DELAY_W-1:0]   script_wdata,
    input  logic                          start,
    input  logic                          abort,
    input  logic [DATA_W-1:0]             observe,
    output logic [DATA_W-1:0]             S,
    output logic                          Run_n,
    output logic                          Continue_n,
    output logic                          dut_reset_n,
    output logic                          busy,
    output logic                          done,
    output logic                          overrun,
    output logic [7:0]                    pass_cnt,
    output logic [7:0]                    fail_cnt
`ifdef SEQ_FAIL_CAPTURE_EN
    ,
    output logic [$clog2(STEPS)-1:0]      fail_step,
    output logic [DATA_W-1:0]             fail_obs
`endif
);

    localparam int ADDR_W  = $clog2(STEPS);
    localparam int ENTRY_W = 3 + DATA_W + DELAY_W;
    localparam int PCNT_W  = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    localparam logic [2:0] OP_SET_S      = 3'd1;
    localparam logic [2:0] OP_PULSE_CONT = 3'd2;
    localparam logic [2:0] OP_PULSE_RUN  = 3'd3;
    localparam logic [2:0] OP_CHECK      = 3'd4;
    localparam logic [2:0] OP_DUT_RESET  = 3'd5;
    localparam logic [2:0] OP_END        = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_PULSE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Script RAM and its registered read port
    logic [ENTRY_W-1:0] r_mem [STEPS];
    logic [ENTRY_W-1:0] r_rdata;

    state_t              r_state,   w_state_nxt;
    logic [ADDR_W-1:0]   r_step,    w_step_nxt;
    logic [DATA_W-1:0]   r_s,       w_s_nxt;
    logic                r_run_n,   w_run_n_nxt;
    logic                r_cont_n,  w_cont_n_nxt;
    logic                r_dres_n,  w_dres_n_nxt;
    logic                r_busy,    w_busy_nxt;
    logic                r_done,    w_done_nxt;
    logic                r_overrun, w_overrun_nxt;
    logic [7:0]          r_pass,    w_pass_nxt;
    logic [7:0]          r_fail,    w_fail_nxt;
    logic [PCNT_W-1:0]   r_pcnt,    w_pcnt_nxt;
    logic [DELAY_W-1:0]  r_wcnt,    w_wcnt_nxt;
    logic [DELAY_W-1:0]  r_delay,   w_delay_nxt;
`ifdef SEQ_FAIL_CAPTURE_EN
    logic                r_fail_seen, w_fail_seen_nxt;
    logic [ADDR_W-1:0]   r_fail_step, w_fail_step_nxt;
    logic [DATA_W-1:0]   r_fail_obs,  w_fail_obs_nxt;
`endif

    logic [2:0]          w_op;
    logic [DATA_W-1:0]   w_value;
    logic [DELAY_W-1:0]  w_delay;
    logic                w_last;
    logic                w_finish;
    logic [DELAY_W-1:0]  w_fin_delay;
    logic                w_advance;

    assign w_op    = r_rdata[ENTRY_W-1 -: 3];
    assign w_value = r_rdata[DELAY_W +: DATA_W];
    assign w_delay = r_rdata[DELAY_W-1:0];
    assign w_last  = (r_step == ADDR_W'(STEPS - 1));

    // Writes are locked out while executing, so r_rdata stays stable for the
    // whole life of a step (EXEC through PULSE/WAIT).
    always_ff @(posedge Clk) begin
        if (script_we && !r_busy) begin
            r_mem[script_addr] <= script_wdata;
        end
        r_rdata <= r_mem[r_step];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_step    <= '0;
            r_s       <= '0;
            r_run_n   <= 1'b1;
            r_cont_n  <= 1'b1;
            r_dres_n  <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_pass    <= '0;
            r_fail    <= '0;
            r_pcnt    <= '0;
            r_wcnt    <= '0;
            r_delay   <= '0;
`ifdef SEQ_FAIL_CAPTURE_EN
            r_fail_seen <= 1'b0;
            r_fail_step <= '0;
            r_fail_obs  <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_step    <= w_step_nxt;
            r_s       <= w_s_nxt;
            r_run_n   <= w_run_n_nxt;
            r_cont_n  <= w_cont_n_nxt;
            r_dres_n  <= w_dres_n_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_overrun <= w_overrun_nxt;
            r_pass    <= w_pass_nxt;
            r_fail    <= w_fail_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_delay   <= w_delay_nxt;
`ifdef SEQ_FAIL_CAPTURE_EN
            r_fail_seen <= w_fail_seen_nxt;
            r_fail_step <= w_fail_step_nxt;
            r_fail_obs  <= w_fail_obs_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_step_nxt    = r_step;
        w_s_nxt       = r_s;
        w_run_n_nxt   = r_run_n;
        w_cont_n_nxt  = r_cont_n;
        w_dres_n_nxt  = r_dres_n;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_overrun_nxt = r_overrun;
        w_pass_nxt    = r_pass;
        w_fail_nxt    = r_fail;
        w_pcnt_nxt    = r_pcnt;
        w_wcnt_nxt    = r_wcnt;
        w_delay_nxt   = r_delay;
`ifdef SEQ_FAIL_CAPTURE_EN
        w_fail_seen_nxt = r_fail_seen;
        w_fail_step_nxt = r_fail_step;
        w_fail_obs_nxt  = r_fail_obs;
`endif
        w_finish    = 1'b0;
        w_fin_delay = '0;
        w_advance   = 1'b0;

        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt   = ST_FETCH;
                    w_step_nxt    = '0;
                    w_pass_nxt    = '0;
                    w_fail_nxt    = '0;
                    w_done_nxt    = 1'b0;
                    w_overrun_nxt = 1'b0;
                    w_busy_nxt    = 1'b1;
`ifdef SEQ_FAIL_CAPTURE_EN
                    w_fail_seen_nxt = 1'b0;
                    w_fail_step_nxt = '0;
                    w_fail_obs_nxt  = '0;
`endif
                end
            end

            ST_FETCH: begin
                w_state_nxt = ST_EXEC;
            end

            ST_EXEC: begin
                w_delay_nxt = w_delay;
                case (w_op)
                    OP_SET_S: begin
                        w_s_nxt     = w_value;
                        w_finish    = 1'b1;
                        w_fin_delay = w_delay;
                    end
                    OP_PULSE_CONT: begin
                        w_cont_n_nxt = 1'b0;
                        w_pcnt_nxt   = PCNT_W'(PULSE_W - 1);
                        w_state_nxt  = ST_PULSE;
                    end
                    OP_PULSE_RUN: begin
                        w_run_n_nxt = 1'b0;
                        w_pcnt_nxt  = PCNT_W'(PULSE_W - 1);
                        w_state_nxt = ST_PULSE;
                    end
                    OP_DUT_RESET: begin
                        w_dres_n_nxt = 1'b0;
                        w_pcnt_nxt   = PCNT_W'(PULSE_W - 1);
                        w_state_nxt  = ST_PULSE;
                    end
                    OP_CHECK: begin
                        if (observe == w_value) begin
                            if (r_pass != 8'hFF) w_pass_nxt = r_pass + 8'd1;
                        end else begin
                            if (r_fail != 8'hFF) w_fail_nxt = r_fail + 8'd1;
`ifdef SEQ_FAIL_CAPTURE_EN
                            if (!r_fail_seen) begin
                                w_fail_seen_nxt = 1'b1;
                                w_fail_step_nxt = r_step;
                                w_fail_obs_nxt  = observe;
                            end
`endif
                        end
                        w_finish    = 1'b1;
                        w_fin_delay = w_delay;
                    end
                    OP_END: begin
                        w_state_nxt = ST_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                    default: begin
                        // WAIT and the reserved opcode
                        w_finish    = 1'b1;
                        w_fin_delay = w_delay;
                    end
                endcase
            end

            ST_PULSE: begin
                // Counter was loaded with PULSE_W-1 so the control is low for
                // exactly PULSE_W cycles including the entry edge.
                if (r_pcnt == '0) begin
                    w_run_n_nxt  = 1'b1;
                    w_cont_n_nxt = 1'b1;
                    w_dres_n_nxt = 1'b1;
                    w_finish     = 1'b1;
                    w_fin_delay  = r_delay;
                end else begin
                    w_pcnt_nxt = r_pcnt - PCNT_W'(1);
                end
            end

            ST_WAIT: begin
                if (r_wcnt <= DELAY_W'(1)) begin
                    w_advance = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt - DELAY_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // Step action complete: either wait out the delay or move on
        if (w_finish) begin
            if (w_fin_delay == '0) begin
                w_advance = 1'b1;
            end else begin
                w_state_nxt = ST_WAIT;
                w_wcnt_nxt  = w_fin_delay;
            end
        end

        // The step counter never wraps; running past the last entry is an overrun
        if (w_advance) begin
            if (w_last) begin
                w_state_nxt   = ST_DONE;
                w_busy_nxt    = 1'b0;
                w_done_nxt    = 1'b1;
                w_overrun_nxt = 1'b1;
            end else begin
                w_step_nxt  = r_step + ADDR_W'(1);
                w_state_nxt = ST_FETCH;
            end
        end

        // Abort overrides everything above, including a same-cycle start
        if (abort) begin
            w_state_nxt  = ST_IDLE;
            w_busy_nxt   = 1'b0;
            w_done_nxt   = 1'b0;
            w_run_n_nxt  = 1'b1;
            w_cont_n_nxt = 1'b1;
            w_dres_n_nxt = 1'b1;
        end
    end

    assign S           = r_s;
    assign Run_n       = r_run_n;
    assign Continue_n  = r_cont_n;
    assign dut_reset_n = r_dres_n;
    assign busy        = r_busy;
    assign done        = r_done;
    assign overrun     = r_overrun;
    assign pass_cnt    = r_pass;
    assign fail_cnt    = r_fail;
`ifdef SEQ_FAIL_CAPTURE_EN
    assign fail_step   = r_fail_step;
    assign fail_obs    = r_fail_obs;
`endif

endmodule

// File: tb/tb_slc3_stim_sequencer.sv
// tb/tb_slc3_stim_sequencer.sv - directed self-checking bench for slc3_stim_sequencer

module tb_slc3_stim_sequencer;

    logic        Clk;
    logic        Reset;
    logic        script_we;
    logic [4:0]  script_addr;
    logic [34:0] script_wdata;
    logic        start;
    logic        abort;
    logic [15:0] observe;
    logic [15:0] S;
    logic        Run_n;
    logic        Continue_n;
    logic        dut_reset_n;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [7:0]  pass_cnt;
    logic [7:0]  fail_cnt;
`ifdef SEQ_FAIL_CAPTURE_EN
    logic [4:0]  fail_step;
    logic [15:0] fail_obs;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] OP_WAIT = 3'd0, OP_SET_S = 3'd1, OP_PCONT = 3'd2,
                           OP_PRUN = 3'd3, OP_CHECK = 3'd4, OP_DRES = 3'd5,
                           OP_END = 3'd7;

    slc3_stim_sequencer #(
        .DATA_W(16), .STEPS(32), .DELAY_W(16), .PULSE_W(4)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .script_we(script_we), .script_addr(script_addr), .script_wdata(script_wdata),
        .start(start), .abort(abort), .observe(observe),
        .S(S), .Run_n(Run_n), .Continue_n(Continue_n), .dut_reset_n(dut_reset_n),
        .busy(busy), .done(done), .overrun(overrun),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`ifdef SEQ_FAIL_CAPTURE_EN
        , .fail_step(fail_step), .fail_obs(fail_obs)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic write_entry(input int addr, input logic [2:0] op,
                               input logic [15:0] val, input logic [15:0] dly);
        @(negedge Clk);
        script_we    = 1'b1;
        script_addr  = addr[4:0];
        script_wdata = {op, val, dly};
        @(negedge Clk);
        script_we    = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #1;
        n_checks++; if (S !== 16'h0000) begin n_fail++; $display("FAIL reset_S: got %h expected 0000", S); end
        n_checks++; if ({Run_n, Continue_n, dut_reset_n} !== 3'b111) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 111", {Run_n, Continue_n, dut_reset_n}); end
        n_checks++; if ({busy, done, overrun} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b expected 000", {busy, done, overrun}); end
        n_checks++; if ({pass_cnt, fail_cnt} !== 16'h0000) begin n_fail++; $display("FAIL reset_counts: got %h expected 0000", {pass_cnt, fail_cnt}); end
`ifdef SEQ_FAIL_CAPTURE_EN
        n_checks++; if ({fail_step, fail_obs} !== 21'h0) begin n_fail++; $display("FAIL reset_capture: got %h expected 0", {fail_step, fail_obs}); end
`endif
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_multiply();
        int run_low = 0, cont_low = 0, dres_low = 0;
        bit got_done = 0;
        write_entry(0, OP_DRES,  16'h0000, 16'd0);
        write_entry(1, OP_SET_S, 16'h0031, 16'd0);
        write_entry(2, OP_PRUN,  16'h0000, 16'd0);
        write_entry(3, OP_SET_S, 16'h0005, 16'd200);
        write_entry(4, OP_PCONT, 16'h0000, 16'd0);
        write_entry(5, OP_SET_S, 16'h2020, 16'd0);
        write_entry(6, OP_PCONT, 16'h0000, 16'd1000);
        write_entry(7, OP_CHECK, 16'hA0A0, 16'd0);
        write_entry(8, OP_END,   16'h0000, 16'd0);
        observe = 16'hA0A0;
        @(negedge Clk);
        start = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge Clk);
            start = 1'b0;
            if (!Run_n) run_low++;
            if (!Continue_n) cont_low++;
            if (!dut_reset_n) dres_low++;
            if (done) begin got_done = 1; break; end
        end
        n_checks++; if (!got_done) begin n_fail++; $display("FAIL mul_timeout: done never set"); end
        n_checks++; if (pass_cnt !== 8'd1) begin n_fail++; $display("FAIL mul_pass: got %0d expected 1", pass_cnt); end
        n_checks++; if (fail_cnt !== 8'd0) begin n_fail++; $display("FAIL mul_fail: got %0d expected 0", fail_cnt); end
        n_checks++; if ({busy, done, overrun} !== 3'b010) begin n_fail++; $display("FAIL mul_status: got %b expected 010", {busy, done, overrun}); end
        n_checks++; if (S !== 16'h2020) begin n_fail++; $display("FAIL mul_S: got %h expected 2020", S); end
        n_checks++; if (run_low != 4 || dres_low != 4 || cont_low != 8) begin n_fail++; $display("FAIL mul_pulses: run %0d dres %0d cont %0d expected 4 4 8", run_low, dres_low, cont_low); end
    endtask

    task automatic test_pulse_timing();
        int first_low = -1, low_cnt = 0, rel = -1, s_at = -1;
        write_entry(0, OP_PCONT, 16'h0000, 16'd3);
        write_entry(1, OP_SET_S, 16'hBEEF, 16'd0);
        write_entry(2, OP_END,   16'h0000, 16'd0);
        @(negedge Clk);
        start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            start = 1'b0;
            if (!Continue_n) begin
                low_cnt++;
                if (first_low < 0) first_low = k;
            end else if (first_low >= 0 && rel < 0) begin
                rel = k;
            end
            if (S == 16'hBEEF && s_at < 0) s_at = k;
        end
        n_checks++; if (first_low != 2) begin n_fail++; $display("FAIL pulse_start: got %0d expected 2", first_low); end
        n_checks++; if (low_cnt != 4) begin n_fail++; $display("FAIL pulse_width: got %0d expected 4", low_cnt); end
        n_checks++; if (s_at - rel != 5) begin n_fail++; $display("FAIL pulse_gap: got %0d expected 5", s_at - rel); end
        n_checks++; if (!done) begin n_fail++; $display("FAIL pulse_done: got %b expected 1", done); end
    endtask

    task automatic test_checks();
        write_entry(0, OP_CHECK, 16'h1234, 16'd0);
        write_entry(1, OP_CHECK, 16'hFFFF, 16'd0);
        write_entry(2, OP_END,   16'h0000, 16'd0);
        observe = 16'h1234;
        pulse_start();
        for (int k = 0; k < 50 && !done; k++) @(negedge Clk);
        n_checks++; if (!done) begin n_fail++; $display("FAIL chk_timeout: done never set"); end
        n_checks++; if (pass_cnt !== 8'd1 || fail_cnt !== 8'd1) begin n_fail++; $display("FAIL chk_counts: got %0d/%0d expected 1/1", pass_cnt, fail_cnt); end
`ifdef SEQ_FAIL_CAPTURE_EN
        n_checks++; if (fail_step !== 5'd1) begin n_fail++; $display("FAIL chk_fail_step: got %0d expected 1", fail_step); end
        n_checks++; if (fail_obs !== 16'h1234) begin n_fail++; $display("FAIL chk_fail_obs: got %h expected 1234", fail_obs); end
`endif
    endtask

    task automatic test_overrun();
        int done_at = -1;
        for (int i = 0; i < 32; i++) write_entry(i, OP_SET_S, 16'h5500 + 16'(i), 16'd0);
        @(negedge Clk);
        start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clk);
            start = 1'b0;
            if (done) begin done_at = k; break; end
        end
        n_checks++; if (done_at != 64) begin n_fail++; $display("FAIL ovr_done_cycle: got %0d expected 64", done_at); end
        n_checks++; if ({busy, done, overrun} !== 3'b011) begin n_fail++; $display("FAIL ovr_status: got %b expected 011", {busy, done, overrun}); end
        n_checks++; if (S !== 16'h551F) begin n_fail++; $display("FAIL ovr_S: got %h expected 551f", S); end
    endtask

    task automatic test_abort();
        write_entry(0, OP_SET_S, 16'h0777, 16'd0);
        write_entry(1, OP_WAIT,  16'h0000, 16'd500);
        write_entry(2, OP_END,   16'h0000, 16'd0);
        pulse_start();
        repeat (20) @(negedge Clk);
        write_entry(2, OP_SET_S, 16'hDEAD, 16'd0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
        abort = 1'b1;
        start = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        start = 1'b0;
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL abort_status: got %b expected 00", {busy, done}); end
        n_checks++; if (S !== 16'h0777) begin n_fail++; $display("FAIL abort_S: got %h expected 0777", S); end
        repeat (3) @(negedge Clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b expected 0", busy); end
        // Entry 2 must still be END: rerun and finish without overrun or S change
        pulse_start();
        for (int k = 0; k < 1000 && !done; k++) @(negedge Clk);
        n_checks++; if ({done, overrun} !== 2'b10 || S !== 16'h0777) begin n_fail++; $display("FAIL we_dropped: got done/ovr %b S %h expected 10 0777", {done, overrun}, S); end
        // Abort cuts a Run pulse short
        write_entry(0, OP_PRUN, 16'h0000, 16'd0);
        write_entry(1, OP_END,  16'h0000, 16'd0);
        pulse_start();
        repeat (3) @(negedge Clk);
        n_checks++; if (Run_n !== 1'b0) begin n_fail++; $display("FAIL abort_pulse_low: got %b expected 0", Run_n); end
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        n_checks++; if ({Run_n, Continue_n, dut_reset_n, busy} !== 4'b1110) begin n_fail++; $display("FAIL abort_pulse_cut: got %b expected 1110", {Run_n, Continue_n, dut_reset_n, busy}); end
    endtask

    task automatic test_reset_mid_pulse();
        bit saw_low = 0;
        write_entry(0, OP_SET_S, 16'h00FF, 16'd0);
        write_entry(1, OP_PCONT, 16'h0000, 16'd0);
        write_entry(2, OP_END,   16'h0000, 16'd0);
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            if (!Continue_n) begin saw_low = 1; break; end
            @(negedge Clk);
        end
        n_checks++; if (!saw_low) begin n_fail++; $display("FAIL rst_pulse_seen: Continue_n never low"); end
        #2 Reset = 1'b1;
        #1;
        n_checks++; if ({Continue_n, busy, S} !== {1'b1, 1'b0, 16'h0000}) begin n_fail++; $display("FAIL rst_async: got cont %b busy %b S %h expected 1 0 0000", Continue_n, busy, S); end
        @(negedge Clk);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        n_checks++; if ({busy, done, Continue_n} !== 3'b001) begin n_fail++; $display("FAIL rst_idle: got %b expected 001", {busy, done, Continue_n}); end
        pulse_start();
        for (int k = 0; k < 50 && !done; k++) @(negedge Clk);
        n_checks++; if (!done || S !== 16'h00FF) begin n_fail++; $display("FAIL rst_ram_kept: got done %b S %h expected 1 00ff", done, S); end
    endtask

    initial begin
        script_we    = 1'b0;
        script_addr  = '0;
        script_wdata = '0;
        start        = 1'b0;
        abort        = 1'b0;
        observe      = 16'h0000;
        test_reset();
        test_multiply();
        test_pulse_timing();
        test_checks();
        test_overrun();
        test_abort();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
